// File: rtl/serial_word_tx.sv
// serial_word_tx: transmit end of the 16-bit serial word link.
// Serializes a parallel word LSB first onto DATA with a one-cycle ENABLE
// strobe per bit, optionally spacing bits by BIT_GAP idle cycles.
// Optional feature macro: SERIAL_TX_DOUBLE_BUFFER_EN adds a one-word holding
// register so a following word streams out with no idle cycle between frames.
module serial_word_tx #(
  parameter int WIDTH   = 16,
  parameter int BIT_GAP = 0
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic             READY,
  output logic             DATA,
  output logic             ENABLE,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BIT  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [7:0]       GAP_LOAD = 8'(BIT_GAP);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gap_q, gap_d;
  logic             ready_q, ready_d;
  logic             data_q, data_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_TX_DOUBLE_BUFFER_EN
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
`endif

  logic accept;
  assign accept = LOAD & ready_q;

  // Next-state logic: frame sequencing, shifting and output decode.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    data_d   = data_q;   // DATA holds its last value when no bit is strobed
    enable_d = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_TX_DOUBLE_BUFFER_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef SERIAL_TX_DOUBLE_BUFFER_EN
        // A word parked on the drain edge is started one edge later.
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = S_BIT;
          cnt_d       = '0;
          enable_d    = 1'b1;
          data_d      = hold_q[0];
        end else if (accept) begin
          shift_d  = DATA_IN;
          state_d  = S_BIT;
          cnt_d    = '0;
          enable_d = 1'b1;
          data_d   = DATA_IN[0];
        end
`else
        if (accept) begin
          shift_d  = DATA_IN;
          state_d  = S_BIT;
          cnt_d    = '0;
          enable_d = 1'b1;
          data_d   = DATA_IN[0];
        end
`endif
      end
      S_BIT: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Last bit just went out: no trailing gap after it.
          done_d  = 1'b1;
          state_d = S_IDLE;
`ifdef SERIAL_TX_DOUBLE_BUFFER_EN
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
            state_d     = S_BIT;
            enable_d    = 1'b1;
            data_d      = hold_q[0];
          end
`endif
        end else if (BIT_GAP > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          enable_d = 1'b1;
          data_d   = shift_d[0];
        end
      end
      S_GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q == 8'd1) begin
          state_d  = S_BIT;
          enable_d = 1'b1;
          data_d   = shift_q[0];
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SERIAL_TX_DOUBLE_BUFFER_EN
    // A word accepted mid-frame (or on the drain edge) is parked.
    if (accept && (state_q != S_IDLE)) begin
      hold_d      = DATA_IN;
      hold_full_d = 1'b1;
    end
    ready_d = !hold_full_d;
`else
    ready_d = (state_d == S_IDLE);
`endif
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      ready_q  <= 1'b1;
      data_q   <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_TX_DOUBLE_BUFFER_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_TX_DOUBLE_BUFFER_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

  assign READY  = ready_q;
  assign DATA   = data_q;
  assign ENABLE = enable_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: two instances (BIT_GAP=0 and BIT_GAP=3) checked
// cycle by cycle against an arithmetic model of the frame timing, plus a
// receiver model that rebuilds each word from DATA on ENABLE cycles.
module tb_serial_word_tx;
  localparam int W = 16;
`ifdef SERIAL_TX_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic CLOCK = 1'b0;
  logic rst_n;
  logic load0, load3;
  logic [W-1:0] din0, din3;
  logic rdy0, dat0, en0, busy0, done0;
  logic rdy3, dat3, en3, busy3, done3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLOCK = ~CLOCK;

  serial_word_tx #(.WIDTH(W), .BIT_GAP(0)) dut0 (
    .CLOCK(CLOCK), .RESET_N(rst_n), .LOAD(load0), .DATA_IN(din0),
    .READY(rdy0), .DATA(dat0), .ENABLE(en0), .BUSY(busy0), .DONE(done0));

  serial_word_tx #(.WIDTH(W), .BIT_GAP(3)) dut3 (
    .CLOCK(CLOCK), .RESET_N(rst_n), .LOAD(load3), .DATA_IN(din3),
    .READY(rdy3), .DATA(dat3), .ENABLE(en3), .BUSY(busy3), .DONE(done3));

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Model: k counts cycles after the accept edge (k=1 is the first ENABLE).
  function automatic int m_len(int gap);
    return W + (W - 1) * gap;
  endfunction

  function automatic logic m_en(int k, int gap);
    int t;
    t = k - 1;
    return (k >= 1) && (t % (gap + 1) == 0) && (t / (gap + 1) < W);
  endfunction

  function automatic logic m_data(logic [W-1:0] w, int k, int gap);
    int b;
    b = (k - 1) / (gap + 1);
    if (b > W - 1) b = W - 1;
    return w[b];
  endfunction

  function automatic logic m_rdy(int k, int len);
    return DB ? 1'b1 : (k > len);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    load0 = 1'b0; din0 = '0;
    load3 = 1'b0; din3 = '0;
    tick(); tick();
    n_checks++;
    if ({rdy0, dat0, en0, busy0, done0} !== 5'b10000)
      $display("FAIL reset_dut0 got %b exp 10000", {rdy0, dat0, en0, busy0, done0});
    else n_pass++;
    n_checks++;
    if ({rdy3, dat3, en3, busy3, done3} !== 5'b10000)
      $display("FAIL reset_dut3 got %b exp 10000", {rdy3, dat3, en3, busy3, done3});
    else n_pass++;
    @(negedge CLOCK);
    rst_n = 1'b1;
    tick(); tick();
    n_checks++;
    if ({rdy0, dat0, en0, busy0, done0} !== 5'b10000)
      $display("FAIL idle_after_reset got %b exp 10000", {rdy0, dat0, en0, busy0, done0});
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [W-1:0] w, rx;
    logic [4:0] exp_v;
    int nb, len;
    len = m_len(0);
    for (int i = 0; i < 4; i++) begin
      w = (i == 0) ? 16'hA5C3 : W'($urandom);
      rx = '0; nb = 0;
      load0 = 1'b1; din0 = w;
      tick();
      load0 = 1'b0; din0 = W'($urandom);
      for (int k = 1; k <= len + 1; k++) begin
        exp_v = {m_rdy(k, len), m_data(w, k, 0), m_en(k, 0), k <= len, k == len + 1};
        n_checks++;
        if ({rdy0, dat0, en0, busy0, done0} !== exp_v)
          $display("FAIL basic w=%h k=%0d got rdy/dat/en/busy/done=%b exp %b",
                   w, k, {rdy0, dat0, en0, busy0, done0}, exp_v);
        else n_pass++;
        if (en0 === 1'b1) begin
          if (nb < W) rx[nb] = dat0;
          nb++;
        end
        if (k <= len) tick();
      end
      n_checks++;
      if (nb != W || rx !== w)
        $display("FAIL basic_rx got %h (%0d bits) exp %h (16 bits)", rx, nb, w);
      else n_pass++;
    end
  endtask

  task automatic test_gap();
    logic [W-1:0] w, rx;
    logic [4:0] exp_v;
    int nb, len;
    len = m_len(3);
    for (int i = 0; i < 3; i++) begin
      w = (i == 0) ? 16'h0001 : W'($urandom);
      rx = '0; nb = 0;
      load3 = 1'b1; din3 = w;
      tick();
      load3 = 1'b0; din3 = W'($urandom);
      for (int k = 1; k <= len + 1; k++) begin
        exp_v = {m_rdy(k, len), m_data(w, k, 3), m_en(k, 3), k <= len, k == len + 1};
        n_checks++;
        if ({rdy3, dat3, en3, busy3, done3} !== exp_v)
          $display("FAIL gap w=%h k=%0d got rdy/dat/en/busy/done=%b exp %b",
                   w, k, {rdy3, dat3, en3, busy3, done3}, exp_v);
        else n_pass++;
        if (en3 === 1'b1) begin
          if (nb < W) rx[nb] = dat3;
          nb++;
        end
        if (k <= len) tick();
      end
      n_checks++;
      if (nb != W || rx !== w)
        $display("FAIL gap_rx got %h (%0d bits) exp %h (16 bits)", rx, nb, w);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w1, w2, rx1, rx2;
    logic [4:0] exp_v;
    int nb1, nb2, len, k2;
    w1 = 16'h1234; w2 = 16'hFFFE;
    rx1 = '0; rx2 = '0; nb1 = 0; nb2 = 0;
    len = m_len(0);
    load0 = 1'b1; din0 = w1;
    tick();
    // LOAD stays high; DATA_IN carries junk until the done cycle.
    for (int k = 1; k <= 2 * (len + 1); k++) begin
      k2 = k - (len + 1);
      if (k <= len + 1)
        exp_v = {k > len, m_data(w1, k, 0), m_en(k, 0), k <= len, k == len + 1};
      else
        exp_v = {k2 > len, m_data(w2, k2, 0), m_en(k2, 0), k2 <= len, k2 == len + 1};
      n_checks++;
      if ({rdy0, dat0, en0, busy0, done0} !== exp_v)
        $display("FAIL b2b k=%0d got rdy/dat/en/busy/done=%b exp %b",
                 k, {rdy0, dat0, en0, busy0, done0}, exp_v);
      else n_pass++;
      if (en0 === 1'b1) begin
        if (k <= len) begin
          if (nb1 < W) rx1[nb1] = dat0;
          nb1++;
        end else begin
          if (nb2 < W) rx2[nb2] = dat0;
          nb2++;
        end
      end
      if (k == len + 1) din0 = w2;
      else din0 = W'($urandom);
      if (k == 2 * (len + 1)) load0 = 1'b0;
      if (k < 2 * (len + 1)) tick();
    end
    n_checks++;
    if (nb1 != W || rx1 !== w1)
      $display("FAIL b2b_rx1 got %h (%0d bits) exp %h", rx1, nb1, w1);
    else n_pass++;
    n_checks++;
    if (nb2 != W || rx2 !== w2)
      $display("FAIL b2b_rx2 got %h (%0d bits) exp %h", rx2, nb2, w2);
    else n_pass++;
    din0 = '0;
    tick();
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] w, rx;
    logic [4:0] exp_v;
    int nb, len;
    len = m_len(0);
    w = 16'hBEEF;
    load0 = 1'b1; din0 = w;
    tick();
    load0 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      exp_v = {m_rdy(k, len), m_data(w, k, 0), m_en(k, 0), 1'b1, 1'b0};
      n_checks++;
      if ({rdy0, dat0, en0, busy0, done0} !== exp_v)
        $display("FAIL prereset k=%0d got %b exp %b", k, {rdy0, dat0, en0, busy0, done0}, exp_v);
      else n_pass++;
      if (k < 8) tick();
    end
    // Bit 7 (a 1) is on the line; reset must clear outputs without a clock edge.
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rdy0, dat0, en0, busy0, done0} !== 5'b10000)
      $display("FAIL midreset got %b exp 10000", {rdy0, dat0, en0, busy0, done0});
    else n_pass++;
    @(negedge CLOCK);
    rst_n = 1'b1;
    tick();
    w = 16'h00FF; rx = '0; nb = 0;
    load0 = 1'b1; din0 = w;
    tick();
    load0 = 1'b0;
    for (int k = 1; k <= len + 1; k++) begin
      exp_v = {m_rdy(k, len), m_data(w, k, 0), m_en(k, 0), k <= len, k == len + 1};
      n_checks++;
      if ({rdy0, dat0, en0, busy0, done0} !== exp_v)
        $display("FAIL postreset k=%0d got %b exp %b", k, {rdy0, dat0, en0, busy0, done0}, exp_v);
      else n_pass++;
      if (en0 === 1'b1) begin
        if (nb < W) rx[nb] = dat0;
        nb++;
      end
      if (k <= len) tick();
    end
    n_checks++;
    if (nb != W || rx !== w)
      $display("FAIL postreset_rx got %h (%0d bits) exp %h", rx, nb, w);
    else n_pass++;
    tick();
  endtask

  task automatic test_double_buffer();
    logic [W-1:0] words [3];
    logic [W-1:0] q [$];
    logic [3*W-1:0] rx;
    logic [4:0] exp_v;
    logic acc, e_rdy, e_dat;
    int nb;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    q = '{16'h1111, 16'h2222, 16'h3333};
    rx = '0; nb = 0;
    load0 = 1'b1; din0 = q[0];
    acc = rdy0 & load0;
    tick();
    if (acc) void'(q.pop_front());
    for (int k = 1; k <= 50; k++) begin
      e_rdy = !(((k >= 2) && (k <= 16)) || ((k >= 18) && (k <= 32)));
      e_dat = (k <= 48) ? words[(k - 1) / W][(k - 1) % W] : words[2][W - 1];
      exp_v = {e_rdy, e_dat, k <= 48, k <= 48, (k == 17) || (k == 33) || (k == 49)};
      n_checks++;
      if ({rdy0, dat0, en0, busy0, done0} !== exp_v)
        $display("FAIL dbuf k=%0d got rdy/dat/en/busy/done=%b exp %b",
                 k, {rdy0, dat0, en0, busy0, done0}, exp_v);
      else n_pass++;
      if (en0 === 1'b1) begin
        if (nb < 3 * W) rx[nb] = dat0;
        nb++;
      end
      load0 = (q.size() > 0);
      din0  = (q.size() > 0) ? q[0] : '0;
      acc = rdy0 & load0;
      tick();
      if (acc) void'(q.pop_front());
    end
    n_checks++;
    if (nb != 3 * W || rx !== {words[2], words[1], words[0]})
      $display("FAIL dbuf_rx got %h (%0d bits) exp %h", rx, nb, {words[2], words[1], words[0]});
    else n_pass++;
    load0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
`ifdef SERIAL_TX_DOUBLE_BUFFER_EN
    test_double_buffer();
`else
    test_back_to_back();
`endif
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
